stopwatch_nd: RTL and testbench

- Parametrised N-digit BCD stopwatch with integrated dynamic-lighting seven-segment driver.
- Successor to the fixed 4-digit free-running counter/display chain. Adds run/stop control, lap freeze, clear, overflow flag, and a configurable digit count and divider ratios.
- Sits at top level between debounced push-buttons and the board's multiplexed common-anode display.

---
 rtl/stopwatch_nd.sv | 188 ++++++++++++++++++
 tb/tb_stopwatch_nd.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_nd.sv
// N-digit BCD stopwatch with run/stop, lap freeze, clear, sticky overflow and a scanned seven-segment driver.
// Define STOPWATCH_BLANK_EN to blank leading zero digits above the decimal point.
module stopwatch_nd #(
    parameter int NDIGITS  = 4,
    parameter int TICK_DIV = 500000,
    parameter int SCAN_DIV = 50000,
    parameter int DP_DIGIT = 2
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START_STOP,
    input  logic               LAP,
    input  logic               CLEAR,
    output logic [7:0]         DOUT,
    output logic [NDIGITS-1:0] DSEL,
    output logic               RUNNING,
    output logic               OVF
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAP, S_HOLD} state_t;

    state_t                 state, next_state;
    logic [2:0]             s1, s2, s3, pulse;
    logic                   p_clr, p_ss, p_lap;
    logic                   counting, do_snap, tick, wrap;
    logic [PW-1:0]          presc;
    logic [SW-1:0]          scan_cnt;
    logic [IW-1:0]          idx;
    logic [4*NDIGITS-1:0]   digits, inc_digits, snapshot, disp;
    logic [NDIGITS-1:0]     blank;
    logic [3:0]             cur_digit;
    logic [6:0]             seg;
    logic                   dp;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Button bits are {clear, start_stop, lap}; s3 delays s2 so each press yields a one-cycle pulse.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= {CLEAR, START_STOP, LAP};
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse = s2 & ~s3;
    assign p_clr = pulse[2];
    assign p_ss  = pulse[1];
    assign p_lap = pulse[0];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= S_IDLE;
        else        state <= next_state;
    end

    // Clear beats start/stop, which beats lap; losing pulses are simply dropped.
    always_comb begin
        next_state = state;
        if (p_clr) begin
            next_state = S_IDLE;
        end else if (p_ss) begin
            case (state)
                S_IDLE:  next_state = S_RUN;
                S_RUN:   next_state = S_HOLD;
                S_LAP:   next_state = S_HOLD;
                default: next_state = S_RUN;
            endcase
        end else if (p_lap) begin
            if (state == S_RUN)      next_state = S_LAP;
            else if (state == S_LAP) next_state = S_RUN;
        end
    end

    always_comb begin
        counting = (state == S_RUN) || (state == S_LAP);
        do_snap  = !p_clr && !p_ss && p_lap && (state == S_RUN);
    end

    assign tick = counting && (presc == PW'(TICK_DIV - 1));

    always_comb begin
        inc_digits = digits;
        wrap       = 1'b1;
        for (int i = 0; i < NDIGITS; i++) begin
            if (wrap) begin
                if (digits[4*i +: 4] == 4'd9) begin
                    inc_digits[4*i +: 4] = 4'd0;
                end else begin
                    inc_digits[4*i +: 4] = digits[4*i +: 4] + 4'd1;
                    wrap = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            presc    <= '0;
            digits   <= '0;
            snapshot <= '0;
            OVF      <= 1'b0;
        end else begin
            if (p_clr) begin
                presc  <= '0;
                digits <= '0;
                OVF    <= 1'b0;
            end else begin
                if (counting) presc <= tick ? '0 : presc + PW'(1);
                if (tick) begin
                    digits <= inc_digits;
                    if (wrap) OVF <= 1'b1;
                end
            end
            if (do_snap) snapshot <= digits;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= (idx == IW'(NDIGITS - 1)) ? '0 : idx + IW'(1);
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    assign disp = (state == S_LAP) ? snapshot : digits;

`ifdef STOPWATCH_BLANK_EN
    // A digit blanks only when it and everything above it is zero, and it sits above the point.
    always_comb begin
        logic lz;
        lz    = 1'b1;
        blank = '0;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            lz       = lz && (disp[4*i +: 4] == 4'd0);
            blank[i] = lz && (i > 0) && (i > DP_DIGIT);
        end
    end
`else
    assign blank = '0;
`endif

    always_comb begin
        cur_digit = disp[4*int'(idx) +: 4];
        seg       = blank[idx] ? 7'b1111111 : seg7(cur_digit);
        dp        = (int'(idx) == DP_DIGIT) ? 1'b0 : 1'b1;
    end

    // Enable and segments share one register stage so they always change together.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            DSEL    <= ~NDIGITS'(1);
            DOUT    <= {(DP_DIGIT == 0) ? 1'b0 : 1'b1, 7'b1000000};
            RUNNING <= 1'b0;
        end else begin
            DSEL    <= ~(NDIGITS'(1) << idx);
            DOUT    <= {dp, seg};
            RUNNING <= counting;
        end
    end

endmodule

// File: tb/tb_stopwatch_nd.sv
// Randomised self-checking bench for stopwatch_nd against a decimal-arithmetic reference model.
module tb_stopwatch_nd;

    localparam int ND   = 4;
    localparam int TD   = 4;
    localparam int SD   = 2;
    localparam int DP   = 2;
    localparam int MAXV = 9999;

    logic          CLK;
    logic          RESET;
    logic          START_STOP, LAP, CLEAR;
    logic [7:0]    DOUT;
    logic [ND-1:0] DSEL;
    logic          RUNNING, OVF;

    int checks   = 0;
    int failures = 0;
    bit checking = 0;

    stopwatch_nd #(.NDIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD), .DP_DIGIT(DP)) dut (
        .CLK(CLK), .RESET(RESET), .START_STOP(START_STOP), .LAP(LAP), .CLEAR(CLEAR),
        .DOUT(DOUT), .DSEL(DSEL), .RUNNING(RUNNING), .OVF(OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_HOLD = 3;

    logic [6:0]    seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                     7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    int            m_state, m_count, m_snap, m_presc, m_scan, m_idx;
    bit            m_ovf;
    logic [2:0]    hist [0:2];
    logic [ND-1:0] exp_dsel;
    logic [7:0]    exp_dout;
    logic          exp_run, exp_ovf;

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: observed=%h expected=%h", tag, $time, observed, expected);
        end
    endtask

    // Reference model: the count is a plain integer, digits come from division.
    initial begin
        forever begin
            @(posedge CLK or negedge RESET);
            if (!RESET) begin
                m_state = M_IDLE; m_count = 0; m_snap = 0; m_presc = 0; m_ovf = 0;
                m_scan = 0; m_idx = 0;
                for (int i = 0; i < 3; i++) hist[i] = 3'b000;
                exp_dsel = ~ND'(1);
                exp_dout = {(DP == 0) ? 1'b0 : 1'b1, 7'b1000000};
                exp_run  = 1'b0;
                exp_ovf  = 1'b0;
            end else begin
                int disp, dig, old_count;
                bit pc, pss, plap, counting, tick;
                logic [6:0] seg;
                disp = (m_state == M_LAP) ? m_snap : m_count;
                dig  = (disp / pow10(m_idx)) % 10;
                seg  = seg_tab[dig];
`ifdef STOPWATCH_BLANK_EN
                if (m_idx > 0 && m_idx > DP && disp < pow10(m_idx)) seg = 7'b1111111;
`endif
                exp_dsel = ~(ND'(1) << m_idx);
                exp_dout = {(m_idx == DP) ? 1'b0 : 1'b1, seg};
                exp_run  = (m_state == M_RUN) || (m_state == M_LAP);

                pc   = hist[1][2] & ~hist[2][2];
                pss  = hist[1][1] & ~hist[2][1];
                plap = hist[1][0] & ~hist[2][0];
                old_count = m_count;
                counting  = (m_state == M_RUN) || (m_state == M_LAP);
                tick      = counting && (m_presc == TD - 1);
                if (counting) m_presc = tick ? 0 : m_presc + 1;
                if (tick) begin
                    if (m_count == MAXV) begin
                        m_count = 0;
                        m_ovf   = 1;
                    end else begin
                        m_count = m_count + 1;
                    end
                end
                if (pc) begin
                    m_state = M_IDLE; m_count = 0; m_presc = 0; m_ovf = 0;
                end else if (pss) begin
                    if (m_state == M_IDLE || m_state == M_HOLD) m_state = M_RUN;
                    else m_state = M_HOLD;
                end else if (plap) begin
                    if (m_state == M_RUN) begin
                        m_state = M_LAP;
                        m_snap  = old_count;
                    end else if (m_state == M_LAP) begin
                        m_state = M_RUN;
                    end
                end
                exp_ovf = m_ovf;

                if (m_scan == SD - 1) begin
                    m_scan = 0;
                    m_idx  = (m_idx + 1) % ND;
                end else begin
                    m_scan = m_scan + 1;
                end
                hist[2] = hist[1];
                hist[1] = hist[0];
                hist[0] = {CLEAR, START_STOP, LAP};
            end
        end
    end

    always @(negedge CLK) begin
        if (checking) begin
            checkOutput("dsel", 32'(DSEL), 32'(exp_dsel));
            checkOutput("dout", 32'(DOUT), 32'(exp_dout));
            checkOutput("running", 32'(RUNNING), 32'(exp_run));
            checkOutput("ovf", 32'(OVF), 32'(exp_ovf));
        end
    end

    task automatic applyStimulus(input logic [2:0] btns, input int hold, input int gap);
        {CLEAR, START_STOP, LAP} = btns;
        repeat (hold) @(negedge CLK);
        {CLEAR, START_STOP, LAP} = 3'b000;
        repeat (gap) @(negedge CLK);
    endtask

    initial begin
        RESET = 1'b1;
        {CLEAR, START_STOP, LAP} = 3'b000;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        checking = 1;
        repeat (3) @(negedge CLK);
        checkOutput("reset_dsel", 32'(DSEL), 32'b1110);
        checkOutput("reset_dout", 32'(DOUT), 32'hC0);
        RESET = 1'b1;
        repeat (40) @(negedge CLK);

        applyStimulus(3'b010, 2, 60);
        applyStimulus(3'b001, 2, 20);
        applyStimulus(3'b001, 2, 10);
        applyStimulus(3'b010, 1, 20);
        applyStimulus(3'b010, 1, 20);
        applyStimulus(3'b110, 2, 15);
        checkOutput("clear_wins_running", 32'(RUNNING), 32'd0);

        applyStimulus(3'b010, 2, 40020);
        checkOutput("ovf_after_wrap", 32'(OVF), 32'd1);
        applyStimulus(3'b100, 1, 6);
        checkOutput("ovf_after_clear", 32'(OVF), 32'd0);

        for (int n = 0; n < 250; n++) begin
            logic [2:0] b;
            b = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) != 0) b[2] = 1'b0;
            applyStimulus(b, $urandom_range(1, 4), $urandom_range(1, 40));
        end

        applyStimulus(3'b100, 1, 5);
        applyStimulus(3'b010, 1, 17);
        #2 RESET = 1'b0;
        @(negedge CLK);
        checkOutput("midrun_reset_dsel", 32'(DSEL), 32'b1110);
        RESET = 1'b1;
        repeat (30) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
